// File: rtl/rect_fall_ctl.sv
// Frame-paced position controller for the rectangle draw stage: tracks the mouse
// while idle, then drops the rectangle under gravity with damped bounces on a click.
module rect_fall_ctl #(
  parameter int RECT_W     = 100,
  parameter int RECT_H     = 150,
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int ACC        = 1,
  parameter int VMAX       = 16,
  parameter int BOUNCE_MIN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        moving
);

  localparam logic [12:0] X_MAX   = 13'(H_ACTIVE - 1 - RECT_W);
  localparam logic [12:0] FLOOR   = 13'(V_ACTIVE - 1 - RECT_H);
  localparam logic [12:0] ACC_V   = 13'(ACC);
  localparam logic [12:0] VMAX_V  = 13'(VMAX);
  localparam logic [12:0] BOUNCE_V = 13'(BOUNCE_MIN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FALL   = 2'd1,
    RISE   = 2'd2,
    LANDED = 2'd3
  } state_t;

  state_t      state_r;
  logic [11:0] vel_r;
  logic        vsync_r;
  logic        left_r;

  logic        tick_s;
  logic        click_s;
  logic [11:0] x_clamp_s;
  logic [11:0] y_clamp_s;
  logic [12:0] fall_sum_s;
  logic [12:0] vel_inc_s;
  logic [11:0] vel_sat_s;
  logic [11:0] rise_y_s;

  assign tick_s  = vsync & ~vsync_r;
  assign click_s = mouse_left & ~left_r;

  // Mouse clamping and per-frame motion arithmetic, all in 13 bits so nothing wraps.
  always_comb begin
    x_clamp_s  = mouse_xpos;
    y_clamp_s  = mouse_ypos;
    fall_sum_s = {1'b0, ypos} + {1'b0, vel_r};
    vel_inc_s  = {1'b0, vel_r} + ACC_V;
    vel_sat_s  = vel_inc_s[11:0];
    rise_y_s   = 12'd0;
    if ({1'b0, mouse_xpos} > X_MAX) begin
      x_clamp_s = X_MAX[11:0];
    end else begin
      x_clamp_s = mouse_xpos;
    end
    if ({1'b0, mouse_ypos} > FLOOR) begin
      y_clamp_s = FLOOR[11:0];
    end else begin
      y_clamp_s = mouse_ypos;
    end
    if (vel_inc_s > VMAX_V) begin
      vel_sat_s = VMAX_V[11:0];
    end else begin
      vel_sat_s = vel_inc_s[11:0];
    end
    if (ypos >= vel_r) begin
      rise_y_s = ypos - vel_r;
    end else begin
      rise_y_s = 12'd0;
    end
  end

  // Edge-detect registers for the frame tick and the left click.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_r <= 1'b0;
      left_r  <= 1'b0;
    end else begin
      vsync_r <= vsync;
      left_r  <= mouse_left;
    end
  end

  // Main sequencer; position, velocity and the moving flag are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      xpos    <= 12'd0;
      ypos    <= 12'd0;
      vel_r   <= 12'd0;
      moving  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          xpos <= x_clamp_s;
          ypos <= y_clamp_s;
          if (click_s) begin
            state_r <= FALL;
            vel_r   <= 12'd0;
            moving  <= 1'b1;
          end
        end
        FALL: begin
          if (tick_s) begin
            if (fall_sum_s >= FLOOR) begin
              ypos <= FLOOR[11:0];
              if ({1'b0, vel_r} >= BOUNCE_V) begin
                state_r <= RISE;
                vel_r   <= vel_r >> 1;
              end else begin
                state_r <= LANDED;
                vel_r   <= 12'd0;
                moving  <= 1'b0;
              end
            end else begin
              ypos  <= fall_sum_s[11:0];
              vel_r <= vel_sat_s;
            end
          end
        end
        RISE: begin
          if (tick_s) begin
            ypos <= rise_y_s;
            // At the apex the velocity restarts from zero heading down.
            if ({1'b0, vel_r} <= ACC_V) begin
              state_r <= FALL;
              vel_r   <= 12'd0;
            end else begin
              vel_r <= vel_r - ACC_V[11:0];
            end
          end
        end
        LANDED: begin
          if (click_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          vel_r   <= 12'd0;
          moving  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fall_ctl.sv
// Directed self-checking bench for rect_fall_ctl with hand-computed trajectories.
module tb_rect_fall_ctl;

  logic        clk;
  logic        rst;
  logic        vsync;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        moving;

  int n_checks;
  int n_errors;

  rect_fall_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .mouse_left (mouse_left),
    .xpos       (xpos),
    .ypos       (ypos),
    .moving     (moving)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
  endtask

  task automatic click();
    mouse_left = 1'b1;
    step();
    mouse_left = 1'b0;
  endtask

  task automatic set_mouse(input int x, input int y);
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
  endtask

  int fall100 [10] = '{100, 101, 103, 106, 110, 115, 121, 128, 136, 145};
  int land_y  [10] = '{440, 441, 443, 446, 449, 447, 446, 446, 447, 449};
  int land_mv [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int rise_y  [3]  = '{441, 434, 428};

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    vsync      = 1'b0;
    mouse_left = 1'b0;
    set_mouse(300, 200);
    step();
    step();
    check("rst_x", int'(xpos), 0);
    check("rst_y", int'(ypos), 0);
    check("rst_mv", int'(moving), 0);
    rst = 1'b0;
    step();
    check("idle_x", int'(xpos), 300);
    check("idle_y", int'(ypos), 200);
    check("idle_mv", int'(moving), 0);

    set_mouse(900, 580);
    step();
    check("clamp_x", int'(xpos), 699);
    check("clamp_y", int'(ypos), 449);
    set_mouse(4095, 100);
    step();
    check("clamp_x4095", int'(xpos), 699);
    check("clamp_y100", int'(ypos), 100);

    // Drop from 100; mouse moves away during the fall and must be ignored.
    set_mouse(300, 100);
    step();
    click();
    set_mouse(50, 50);
    check("fall_start_y", int'(ypos), 100);
    check("fall_start_mv", int'(moving), 1);
    for (int i = 0; i < 10; i++) begin
      frame();
      check($sformatf("fall100_y%0d", i + 1), int'(ypos), fall100[i]);
    end
    check("fall100_x", int'(xpos), 300);
    check("fall100_mv", int'(moving), 1);

    // One-cycle reset in the middle of the fall.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_x", int'(xpos), 0);
    check("midrst_y", int'(ypos), 0);
    check("midrst_mv", int'(moving), 0);
    step();
    check("midrst_follow_x", int'(xpos), 50);
    check("midrst_follow_y", int'(ypos), 50);

    // Drop from 0: velocity must restart at zero after the reset.
    set_mouse(300, 0);
    step();
    click();
    for (int t = 1; t <= 37; t++) begin
      frame();
      if (t == 1)  check("drop0_t1", int'(ypos), 0);
      if (t == 2)  check("drop0_t2", int'(ypos), 1);
      if (t == 16) check("drop0_t16", int'(ypos), 120);
      if (t == 36) check("drop0_t36", int'(ypos), 440);
    end
    check("drop0_floor", int'(ypos), 449);
    check("drop0_mv", int'(moving), 1);
    for (int i = 0; i < 3; i++) begin
      frame();
      check($sformatf("rise_y%0d", i + 1), int'(ypos), rise_y[i]);
    end

    // Drop from 440: small bounce, short rise, then landing.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_mouse(300, 440);
    step();
    click();
    for (int i = 0; i < 10; i++) begin
      frame();
      check($sformatf("land_y%0d", i + 1), int'(ypos), land_y[i]);
      check($sformatf("land_mv%0d", i + 1), int'(moving), land_mv[i]);
    end
    for (int i = 0; i < 10; i++) begin
      frame();
    end
    check("landed_hold_y", int'(ypos), 449);
    check("landed_hold_x", int'(xpos), 300);
    check("landed_hold_mv", int'(moving), 0);

    // Click and tick in the same cycle while landed, then hold the button.
    set_mouse(123, 45);
    mouse_left = 1'b1;
    vsync      = 1'b1;
    step();
    check("lclick_y", int'(ypos), 449);
    check("lclick_mv", int'(moving), 0);
    vsync = 1'b0;
    step();
    check("relidle_x", int'(xpos), 123);
    check("relidle_y", int'(ypos), 45);
    for (int i = 0; i < 3; i++) begin
      frame();
    end
    check("hold_x", int'(xpos), 123);
    check("hold_y", int'(ypos), 45);
    check("hold_mv", int'(moving), 0);
    mouse_left = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
